// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   fetch_state_e : fetch sequencer states (request, issue, halt)
//   HLT_ENCODING  : instruction word that stops fetch when FETCH_HALT_EN is defined
//   BR_ADDR26_*   : bit positions of the unconditional branch offset field
//   COND_ADDR19_* : bit positions of the conditional branch offset field
package fetch_pkg;

    localparam int unsigned INSTR_WIDTH = 32;

    localparam logic [INSTR_WIDTH-1:0] HLT_ENCODING = 32'hD440_0000;

    localparam int unsigned BR_ADDR26_MSB   = 25;
    localparam int unsigned BR_ADDR26_LSB   = 0;
    localparam int unsigned BR_ADDR26_W     = BR_ADDR26_MSB - BR_ADDR26_LSB + 1;
    localparam int unsigned COND_ADDR19_MSB = 23;
    localparam int unsigned COND_ADDR19_LSB = 5;
    localparam int unsigned COND_ADDR19_W   = COND_ADDR19_MSB - COND_ADDR19_LSB + 1;

    typedef enum logic [1:0] {
        StReq,
        StIssue,
        StHalt
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_if.sv
// Bundles the instruction-memory and decode-side signals of the fetch stage.
//   master : the fetch stage (drives request, address, instruction, pc_out, halted)
//   slave  : memory + decode/control environment (drives ack, data, ready, branch controls)
interface instr_fetch_if
    import fetch_pkg::*;
#(
    parameter int unsigned PC_WIDTH = 64
);
    // Instruction memory side
    logic                   imem_req;
    logic [PC_WIDTH-1:0]    imem_addr;
    logic                   imem_ack;
    logic [INSTR_WIDTH-1:0] imem_data;
    // Decode side
    logic [INSTR_WIDTH-1:0] instr;
    logic                   instr_valid;
    logic                   instr_ready;
    logic [PC_WIDTH-1:0]    pc_out;
    logic                   br_taken;
    logic                   uncond_br;
    logic                   halted;

    modport master (
        output imem_req, imem_addr, instr, instr_valid, pc_out, halted,
        input  imem_ack, imem_data, instr_ready, br_taken, uncond_br
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_valid, pc_out, halted,
        output imem_ack, imem_data, instr_ready, br_taken, uncond_br
    );

endinterface

// File: rtl/branch_target.sv
// Combinational branch target adder.
//   instr     : instruction holding the offset field
//   uncond_br : 1 selects the 26-bit field instr[25:0], 0 the 19-bit field instr[23:5]
//   pc        : PC of the branch instruction
//   target    : pc + (sign-extended field << 2), wrapping modulo 2^PC_WIDTH
module branch_target
    import fetch_pkg::*;
#(
    parameter int unsigned PC_WIDTH = 64
) (
    input  logic [INSTR_WIDTH-1:0] instr,
    input  logic                   uncond_br,
    input  logic [PC_WIDTH-1:0]    pc,
    output logic [PC_WIDTH-1:0]    target
);

    logic [BR_ADDR26_W-1:0]   br_addr26;
    logic [COND_ADDR19_W-1:0] cond_addr19;
    logic [PC_WIDTH-1:0]      offset_sext;
    logic                     unused_opcode;

    assign br_addr26     = instr[BR_ADDR26_MSB:BR_ADDR26_LSB];
    assign cond_addr19   = instr[COND_ADDR19_MSB:COND_ADDR19_LSB];
    // Opcode bits are decoded elsewhere; only the offset fields matter here.
    assign unused_opcode = ^instr[INSTR_WIDTH-1:BR_ADDR26_MSB+1];

    // Sign-extend to the full PC width first so the shift cannot drop the sign.
    always_comb begin
        offset_sext = '0;
        if (uncond_br) begin
            offset_sext = {{(PC_WIDTH-BR_ADDR26_W){br_addr26[BR_ADDR26_W-1]}}, br_addr26};
        end else begin
            offset_sext = {{(PC_WIDTH-COND_ADDR19_W){cond_addr19[COND_ADDR19_W-1]}},
                           cond_addr19};
        end
    end

    assign target = pc + (offset_sext << 2);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: holds the PC, fetches 32-bit words over a req/ack handshake
// and presents them to decode over a valid/ready handshake. The next PC (PC+4 or a
// branch target) is resolved in the cycle decode accepts the instruction.
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : instr_fetch_if.master (imem_req/addr/ack/data, instr/instr_valid/instr_ready,
//           pc_out, br_taken, uncond_br, halted)
// Optional build macro FETCH_HALT_EN: accepting HLT #0 (32'hD4400000) parks the stage in
// a halt state until reset; without it halted is tied low and HLT is an ordinary word.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned        PC_WIDTH = 64,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic           clk,
    input  logic           reset,
    instr_fetch_if.master  bus
);

    fetch_state_e           state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [PC_WIDTH-1:0]    pc_out_q, pc_out_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [PC_WIDTH-1:0]    br_target;
    logic                   req;
    logic                   valid;
    logic                   halted;

    branch_target #(
        .PC_WIDTH (PC_WIDTH)
    ) u_branch_target (
        .instr     (instr_q),
        .uncond_br (bus.uncond_br),
        .pc        (pc_out_q),
        .target    (br_target)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        pc_out_d = pc_out_q;
        instr_d  = instr_q;
        req      = 1'b0;
        valid    = 1'b0;
        halted   = 1'b0;

        unique case (state_q)
            StReq: begin
                req = 1'b1;
                if (bus.imem_ack) begin
                    instr_d  = bus.imem_data;
                    pc_out_d = pc_q;
                    state_d  = StIssue;
                end
            end
            StIssue: begin
                valid = 1'b1;
                if (bus.instr_ready) begin
                    state_d = StReq;
                    pc_d    = bus.br_taken ? br_target : pc_out_q + PC_WIDTH'(4);
`ifdef FETCH_HALT_EN
                    if (instr_q == HLT_ENCODING) begin
                        state_d = StHalt;
                        pc_d    = pc_q;
                    end
`endif
                end
            end
            StHalt: begin
`ifdef FETCH_HALT_EN
                halted = 1'b1;
`else
                state_d = StReq;
`endif
            end
            default: begin
                state_d = StReq;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StReq;
            pc_q     <= RESET_PC;
            pc_out_q <= RESET_PC;
            instr_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            pc_out_q <= pc_out_d;
            instr_q  <= instr_d;
        end
    end

    // The request is gated by reset so memory never sees a fetch while reset is held.
    assign bus.imem_req    = req & ~reset;
    assign bus.imem_addr   = pc_q;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = valid;
    assign bus.pc_out      = pc_out_q;
    assign bus.halted      = halted;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch with a scoreboard of expected
// (address, instruction) pairs pushed on each memory ack and popped on issue.
module tb_instr_fetch;
    import fetch_pkg::*;

    localparam int unsigned PW = 64;
    localparam logic [31:0] HLT = 32'hD440_0000;

    logic clk = 1'b0;
    logic reset = 1'b1;

    instr_fetch_if #(.PC_WIDTH(PW)) bus ();

    instr_fetch #(
        .PC_WIDTH (PW),
        .RESET_PC (64'h0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expects the DUT in the request state at addr; acks after 'waits' cycles and
    // checks the issued instruction against the scoreboard.
    task automatic fetch_one(input logic [63:0] addr, input logic [31:0] data,
                             input int waits);
        exp_t e;
        chk("req_high", 64'(bus.imem_req), 64'd1);
        chk("req_addr", bus.imem_addr, addr);
        chk("valid_low_in_req", 64'(bus.instr_valid), 64'd0);
        for (int i = 0; i < waits; i++) begin
            tick();
            chk("req_held", 64'(bus.imem_req), 64'd1);
            chk("addr_held", bus.imem_addr, addr);
        end
        bus.imem_ack  = 1'b1;
        bus.imem_data = data;
        sb.push_back('{addr: addr, data: data});
        #1;
        chk("valid_not_with_ack", 64'(bus.instr_valid), 64'd0);
        tick();
        bus.imem_ack  = 1'b0;
        bus.imem_data = $urandom;
        chk("valid_after_ack", 64'(bus.instr_valid), 64'd1);
        e = sb.pop_front();
        chk("instr", 64'(bus.instr), 64'(e.data));
        chk("pc_out", bus.pc_out, e.addr);
        chk("req_low_in_issue", 64'(bus.imem_req), 64'd0);
        chk("not_halted", 64'(bus.halted), 64'd0);
    endtask

    task automatic accept(input logic br, input logic unc);
        bus.instr_ready = 1'b1;
        bus.br_taken    = br;
        bus.uncond_br   = unc;
        tick();
        bus.instr_ready = 1'b0;
        bus.br_taken    = 1'($urandom);
        bus.uncond_br   = 1'($urandom);
    endtask

    initial begin
        bus.imem_ack    = 1'b0;
        bus.imem_data   = '0;
        bus.instr_ready = 1'b0;
        bus.br_taken    = 1'b0;
        bus.uncond_br   = 1'b0;

        // Reset held two cycles
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_req", 64'(bus.imem_req), 64'd0);
            chk("rst_valid", 64'(bus.instr_valid), 64'd0);
            chk("rst_halted", 64'(bus.halted), 64'd0);
        end
        reset = 1'b0;
        #1;
        chk("post_rst_req", 64'(bus.imem_req), 64'd1);
        chk("post_rst_addr", bus.imem_addr, 64'h0);

        // Sequential fetch: zero-wait then three-wait
        fetch_one(64'h0, 32'h9100_0000, 0);
        accept(1'b0, 1'b0);
        fetch_one(64'h4, 32'h9100_0421, 3);

        // Backpressure with a stray ack that must be ignored
        for (int i = 0; i < 3; i++) begin
            bus.imem_ack  = (i == 1);
            bus.imem_data = 32'hDEAD_BEEF;
            tick();
            chk("bp_valid", 64'(bus.instr_valid), 64'd1);
            chk("bp_instr", 64'(bus.instr), 64'h9100_0421);
            chk("bp_pc_out", bus.pc_out, 64'h4);
            chk("bp_req", 64'(bus.imem_req), 64'd0);
        end
        bus.imem_ack = 1'b0;
        accept(1'b0, 1'b0);

        // Unconditional branch back by 2 words: 8 - 8 = 0
        fetch_one(64'h8, 32'h17FF_FFFE, 1);
        accept(1'b1, 1'b1);
        // Unconditional forward by 4 words: 0 -> 0x10
        fetch_one(64'h0, 32'h1400_0004, 0);
        accept(1'b1, 1'b1);
        // Conditional taken, field 5: 0x10 -> 0x24
        fetch_one(64'h10, 32'h5400_00A0, 2);
        accept(1'b1, 1'b0);
        // Back to 0x10 (field -5)
        fetch_one(64'h24, 32'h17FF_FFFB, 0);
        accept(1'b1, 1'b1);
        // Same conditional, not taken: 0x10 -> 0x14
        fetch_one(64'h10, 32'h5400_00A0, 0);
        accept(1'b0, 1'b1);
        // Conditional taken with field -1: 0x14 -> 0x10
        fetch_one(64'h14, 32'h54FF_FFE0, 1);
        accept(1'b1, 1'b0);
        // Branch below zero wraps, then PC+4 wraps back to 0
        fetch_one(64'h10, 32'h17FF_FFFB, 0);
        accept(1'b1, 1'b1);
        fetch_one(64'hFFFF_FFFF_FFFF_FFFC, 32'h9100_0000, 0);
        accept(1'b0, 1'b0);
        fetch_one(64'h0, 32'h9100_0000, 0);
        accept(1'b0, 1'b0);

        // Reset in a request cycle with a coincident ack
        chk("pre_rst_addr", bus.imem_addr, 64'h4);
        reset         = 1'b1;
        bus.imem_ack  = 1'b1;
        bus.imem_data = 32'h9100_0011;
        #1;
        chk("rst_gates_req", 64'(bus.imem_req), 64'd0);
        tick();
        chk("rst_ack_dropped", 64'(bus.instr_valid), 64'd0);
        reset        = 1'b0;
        bus.imem_ack = 1'b0;
        #1;
        chk("rst_pc", bus.imem_addr, 64'h0);
        tick();
        chk("rst_still_invalid", 64'(bus.instr_valid), 64'd0);

        // HLT handling
        fetch_one(64'h0, HLT, 1);
        accept(1'b0, 1'b0);
`ifdef FETCH_HALT_EN
        for (int i = 0; i < 12; i++) begin
            bus.imem_ack = i[0];
            chk("halt_flag", 64'(bus.halted), 64'd1);
            chk("halt_req", 64'(bus.imem_req), 64'd0);
            chk("halt_valid", 64'(bus.instr_valid), 64'd0);
            tick();
        end
        bus.imem_ack = 1'b0;
`else
        chk("hlt_no_halt", 64'(bus.halted), 64'd0);
        fetch_one(64'h4, 32'h9100_0000, 0);
        accept(1'b0, 1'b0);
        chk("hlt_seq_addr", bus.imem_addr, 64'h8);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
